// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: holds the PLL in reset, qualifies a filtered lock, then releases
// the core reset. It re-runs on lock loss, on a lock timeout or on a software request.
module pll_reset_seq #(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned LOCK_FILTER  = 1024,
    parameter int unsigned TIMEOUT      = 65535
) (
    input  logic       clock_in,
    input  logic       resetn,
    input  logic       pll_locked,
    input  logic       restart_req,
    output logic       pll_resetb,
    output logic       core_reset,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] lock_lost_count,
    output logic [7:0] retry_count
);

    typedef enum logic [1:0] {
        StResetPll = 2'd0,
        StWaitLock = 2'd1,
        StRun      = 2'd2
    } state_e;

    localparam logic [15:0] LP_RESET_LAST   = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] LP_LOCK_LAST    = 16'(LOCK_FILTER - 1);
    localparam logic [15:0] LP_TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_e      r_state;
    logic        r_lock_meta;
    logic        r_lock_s;
    logic [15:0] r_cycle_cnt;
    logic [15:0] r_lock_cnt;
    logic [15:0] r_timeout_cnt;
    logic [7:0]  r_lost_cnt;
    logic [7:0]  r_retry_cnt;

    logic        w_lock_done;
    logic        w_timeout;

    // pll_locked is asynchronous to clock_in; only r_lock_s is used past this point.
    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_s    <= r_lock_meta;
        end
    end

    assign w_lock_done = r_lock_s && (r_lock_cnt == LP_LOCK_LAST);
    assign w_timeout   = (r_timeout_cnt == LP_TIMEOUT_LAST);

    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            r_state       <= StResetPll;
            r_cycle_cnt   <= 16'd0;
            r_lock_cnt    <= 16'd0;
            r_timeout_cnt <= 16'd0;
            r_lost_cnt    <= 8'd0;
            r_retry_cnt   <= 8'd0;
        end else begin
            unique case (r_state)
                StResetPll: begin
                    // restart_req is deliberately ignored here so the hold is never stretched
                    if (r_cycle_cnt == LP_RESET_LAST) begin
                        r_state       <= StWaitLock;
                        r_cycle_cnt   <= 16'd0;
                        r_lock_cnt    <= 16'd0;
                        r_timeout_cnt <= 16'd0;
                    end else begin
                        r_cycle_cnt <= r_cycle_cnt + 16'd1;
                    end
                end
                StWaitLock: begin
                    if (restart_req) begin
                        r_state       <= StResetPll;
                        r_cycle_cnt   <= 16'd0;
                        r_lock_cnt    <= 16'd0;
                        r_timeout_cnt <= 16'd0;
                    end else if (w_lock_done) begin
                        // A qualified lock wins over a coincident timeout.
                        r_state <= StRun;
                    end else if (w_timeout) begin
                        r_state       <= StResetPll;
                        r_cycle_cnt   <= 16'd0;
                        r_lock_cnt    <= 16'd0;
                        r_timeout_cnt <= 16'd0;
                        if (r_retry_cnt != 8'hFF) begin
                            r_retry_cnt <= r_retry_cnt + 8'd1;
                        end
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt + 16'd1;
                        r_lock_cnt    <= r_lock_s ? r_lock_cnt + 16'd1 : 16'd0;
                    end
                end
                StRun: begin
                    if (!r_lock_s || restart_req) begin
                        r_state       <= StResetPll;
                        r_cycle_cnt   <= 16'd0;
                        r_lock_cnt    <= 16'd0;
                        r_timeout_cnt <= 16'd0;
                        // A lock loss is counted even when a restart coincides with it.
                        if (!r_lock_s && (r_lost_cnt != 8'hFF)) begin
                            r_lost_cnt <= r_lost_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state       <= StResetPll;
                    r_cycle_cnt   <= 16'd0;
                    r_lock_cnt    <= 16'd0;
                    r_timeout_cnt <= 16'd0;
                end
            endcase
        end
    end

    assign pll_resetb      = (r_state != StResetPll);
    assign core_reset      = (r_state != StRun);
    assign ready           = (r_state == StRun);
    assign state           = r_state;
    assign lock_lost_count = r_lost_cnt;
    assign retry_count     = r_retry_cnt;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with RESET_CYCLES=4, LOCK_FILTER=8, TIMEOUT=32.
module tb_pll_reset_seq;

    logic       clock_in;
    logic       resetn;
    logic       pll_locked;
    logic       restart_req;
    logic       pll_resetb;
    logic       core_reset;
    logic       ready;
    logic [1:0] state;
    logic [7:0] lock_lost_count;
    logic [7:0] retry_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       lock;
        logic       restart;
        logic [1:0] exp_state;
        logic [7:0] exp_lost;
        logic [7:0] exp_retry;
    } vec_t;

    vec_t vec_q[$];

    pll_reset_seq #(
        .RESET_CYCLES(4),
        .LOCK_FILTER (8),
        .TIMEOUT     (32)
    ) dut (
        .clock_in       (clock_in),
        .resetn         (resetn),
        .pll_locked     (pll_locked),
        .restart_req    (restart_req),
        .pll_resetb     (pll_resetb),
        .core_reset     (core_reset),
        .ready          (ready),
        .state          (state),
        .lock_lost_count(lock_lost_count),
        .retry_count    (retry_count)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Outputs are a pure function of the state, so expected outputs derive from it.
    task automatic check_outputs(input string tag, input int exp_state,
                                 input int exp_lost, input int exp_retry);
        check({tag, " state"}, int'(state), exp_state);
        check({tag, " pll_resetb"}, int'(pll_resetb), (exp_state != 0) ? 1 : 0);
        check({tag, " core_reset"}, int'(core_reset), (exp_state != 2) ? 1 : 0);
        check({tag, " ready"}, int'(ready), (exp_state == 2) ? 1 : 0);
        check({tag, " lock_lost_count"}, int'(lock_lost_count), exp_lost);
        check({tag, " retry_count"}, int'(retry_count), exp_retry);
    endtask

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic add(input int n, input logic lock, input logic rst,
                       input logic [1:0] st, input logic [7:0] lost);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.lock      = lock;
            v.restart   = rst;
            v.exp_state = st;
            v.exp_lost  = lost;
            v.exp_retry = 8'd0;
            vec_q.push_back(v);
        end
    endtask

    // Holds resetn low across two edges and releases it just after an edge.
    task automatic do_reset();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    initial begin
        int exp_st;
        resetn      = 1'b0;
        pll_locked  = 1'b1;
        restart_req = 1'b0;
        #3;
        check_outputs("reset_no_clock", 0, 0, 0);

        // Row n is checked just after edge n following reset release.
        add(3, 1, 0, 0, 0);  // 1-3 PLL hold
        add(8, 1, 0, 1, 0);  // 4-11 lock filter
        add(1, 1, 0, 2, 0);  // 12 RUN
        add(1, 0, 0, 2, 0);  // 13 single-cycle lock drop
        add(1, 1, 0, 2, 0);  // 14
        add(4, 1, 0, 0, 1);  // 15-18 lock lost, rerun
        add(8, 1, 0, 1, 1);  // 19-26
        add(1, 1, 0, 2, 1);  // 27
        add(1, 0, 0, 2, 1);  // 28 drop seen by FSM at 30
        add(1, 1, 0, 2, 1);  // 29
        add(1, 1, 1, 0, 2);  // 30 restart coincident with lock loss
        add(1, 1, 0, 0, 2);  // 31
        add(1, 1, 1, 0, 2);  // 32 restart ignored in hold
        add(1, 1, 0, 0, 2);  // 33
        add(8, 1, 0, 1, 2);  // 34-41
        add(1, 1, 0, 2, 2);  // 42
        add(2, 0, 0, 2, 2);  // 43-44
        add(3, 0, 0, 0, 3);  // 45-47
        add(1, 1, 0, 0, 3);  // 48
        add(6, 1, 0, 1, 3);  // 49-54 lock_s high from 50
        add(1, 0, 0, 1, 3);  // 55 lock_s low at 57 breaks 7-high run
        add(9, 1, 0, 1, 3);  // 56-64
        add(1, 1, 0, 2, 3);  // 65 after 8 fresh highs

        step();
        check_outputs("held_in_reset", 0, 0, 0);
        resetn = 1'b1;
        foreach (vec_q[i]) begin
            pll_locked  = vec_q[i].lock;
            restart_req = vec_q[i].restart;
            step();
            check_outputs($sformatf("vec%0d", i + 1), int'(vec_q[i].exp_state),
                          int'(vec_q[i].exp_lost), int'(vec_q[i].exp_retry));
        end
        restart_req = 1'b0;

        // Async reset in WAIT_LOCK with the lock counter at 5.
        pll_locked = 1'b1;
        do_reset();
        for (int k = 1; k <= 9; k++) step();
        check("wait_before_abort state", int'(state), 1);
        #2;
        resetn = 1'b0;
        #1;
        check_outputs("async_abort", 0, 0, 0);
        step();
        resetn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_st = (k < 4) ? 0 : ((k < 12) ? 1 : 2);
            check($sformatf("after_abort edge%0d state", k), int'(state), exp_st);
        end
        check("after_abort ready", int'(ready), 1);

        // Lock never arrives: one retry per 36 edges, saturating at 255.
        pll_locked = 1'b0;
        do_reset();
        for (int p = 1; p <= 300; p++) begin
            for (int k = 1; k <= 36; k++) begin
                step();
                if (p <= 2) begin
                    exp_st = (k < 4) ? 0 : ((k < 36) ? 1 : 0);
                    check($sformatf("retry p%0d edge%0d state", p, k), int'(state), exp_st);
                end
            end
            check($sformatf("retry p%0d state", p), int'(state), 0);
            check($sformatf("retry p%0d retry_count", p), int'(retry_count),
                  (p > 255) ? 255 : p);
        end
        check("retry lock_lost_count", int'(lock_lost_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 SHALL provide parameter RESET_CYCLES, default 16: number of clock_in cycles pll_resetb is held low per PLL reset.
REQ-002 SHALL provide parameter LOCK_FILTER, default 1024: number of consecutive synchronized lock-high cycles required before release.
REQ-003 SHALL provide parameter TIMEOUT, default 65535: maximum WAIT_LOCK cycles before the PLL is reset again; legal ranges are 1..65535 for all parameters and TIMEOUT > LOCK_FILTER.
REQ-004 clock_in  input  1  reference clock (pre-PLL oscillator); only clock of the block.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 pll_locked  input  1  PLL LOCK output, asynchronous to clock_in.
REQ-007 restart_req  input  1  single-cycle software request to re-run the PLL sequence.
REQ-008 pll_resetb  output  1  drives PLL RESETB (low = PLL held in reset).
REQ-009 core_reset  output  1  active-high reset for logic clocked by the PLL output.
REQ-010 ready  output  1  high while the PLL clock is qualified.
REQ-011 state  output  2  current state encoding: 0 RESET_PLL, 1 WAIT_LOCK, 2 RUN.
REQ-012 lock_lost_count  output  8  saturating count of lock losses seen in RUN.
REQ-013 retry_count  output  8  saturating count of WAIT_LOCK timeouts.

Function
REQ-014 pll_locked SHALL pass through a 2-flop synchronizer (lock_s); only lock_s is used internally.
REQ-015 Outputs SHALL be decoded from the state register only: pll_resetb = (state != RESET_PLL), core_reset = (state != RUN), ready = (state == RUN); no combinational input-to-output path.
REQ-016 RESET_PLL: the 16-bit cycle counter SHALL increment every cycle from 0; at count RESET_CYCLES-1 the block SHALL go to WAIT_LOCK with all counters cleared, so pll_resetb is low for exactly RESET_CYCLES cycles.
REQ-017 WAIT_LOCK: the lock counter SHALL increment when lock_s=1 and clear to 0 when lock_s=0; when lock_s=1 and the lock counter equals LOCK_FILTER-1, the next state SHALL be RUN.
REQ-018 WAIT_LOCK: the timeout counter SHALL increment every cycle; at TIMEOUT-1 without a REQ-017 transition, the next state SHALL be RESET_PLL and retry_count SHALL increment, saturating at 255.
REQ-019 A REQ-017 transition and a REQ-018 timeout in the same cycle SHALL resolve to RUN, with no retry_count increment.
REQ-020 RUN: lock_s=0 SHALL cause the next state to be RESET_PLL and lock_lost_count to increment, saturating at 255.
REQ-021 restart_req=1 in WAIT_LOCK or RUN SHALL cause the next state to be RESET_PLL with no counter increment; in RESET_PLL it SHALL be ignored and SHALL NOT restart the cycle count.
REQ-022 restart_req coincident with a RUN lock loss SHALL go to RESET_PLL and SHALL increment lock_lost_count.
REQ-023 Every entry to RESET_PLL SHALL clear the cycle, lock and timeout counters.
REQ-024 Latency: a pll_locked fall in RUN SHALL assert core_reset and deassert ready no later than 3 clock_in edges afterwards (2 synchronizer edges + 1 state edge).

Reset
REQ-025 resetn=0 SHALL asynchronously force state=RESET_PLL, all counters and synchronizer flops to 0, lock_lost_count=0 and retry_count=0, giving pll_resetb=0, core_reset=1, ready=0.
REQ-026 resetn asserted mid-sequence, in any state, SHALL abort the sequence immediately; after release, the sequence SHALL restart from RESET_PLL with a full RESET_CYCLES hold.

Verification (RESET_CYCLES=4, LOCK_FILTER=8, TIMEOUT=32)
REQ-027 pll_locked tied 1 and resetn released -> pll_resetb=0 for 4 edges, then state=1, then ready=1 and core_reset=0 exactly 8 edges later.
REQ-028 pll_locked held 0 -> state 1 for 32 cycles, then back to 0, retry_count=1; repeated 300 times -> retry_count stays at 255.
REQ-029 In RUN, pll_locked drops for 1 cycle -> core_reset=1 within 3 edges, lock_lost_count=1, and the full sequence reruns to ready.
REQ-030 In WAIT_LOCK, lock_s high 7 cycles, low 1 cycle, then high -> the lock counter restarts and ready rises only after 8 further consecutive high cycles.
REQ-031 restart_req pulsed in RUN on the same edge lock_s falls -> state=0, lock_lost_count increments by exactly 1; restart_req pulsed in RESET_PLL -> the hold still lasts exactly 4 cycles.
REQ-032 resetn pulsed low in WAIT_LOCK with lock counter at 5 -> outputs return to their reset values immediately with no clock edge; after release, ready is reached only after 4 + 8 cycles.
